intersection_controller: RTL

INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

---
 rtl/intersection_controller.sv | 103 ++++++++++
 1 files changed

// File: rtl/intersection_controller.sv
`timescale 1ns/100ps
// Two-road traffic light with a pedestrian walk phase. Lamps are a pure decode of the state register, so outputs change one clk after a tick edge.
// No handshake: tick=0 freezes the timer and the state, and the side sensor and ped button are sampled only as demand.
module intersection_controller #(
  parameter int T_MIN_GREEN = 20,
  parameter int T_MAX_GREEN = 60,
  parameter int T_YELLOW    = 5,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 10,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       side_sensor,
  input  logic       ped_req,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    M_GREEN  = 3'd0,
    M_YELLOW = 3'd1,
    ALLRED_A = 3'd2,
    S_GREEN  = 3'd3,
    S_YELLOW = 3'd4,
    ALLRED_B = 3'd5,
    WALK     = 3'd6,
    BAD      = 3'd7
  } state_e;

  // Timer values on the last tick of each interval.
  localparam logic [CNT_W-1:0] MIN_END  = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_END  = CNT_W'(T_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_END  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_END   = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] WALK_END = CNT_W'(T_WALK - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_pending_q, ped_pending_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= M_GREEN;
      timer_q       <= '0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      M_GREEN:
        if (tick && timer_q >= MIN_END && (side_sensor || ped_pending_q)) state_d = M_YELLOW;
      M_YELLOW:
        if (tick && timer_q == YEL_END) state_d = ALLRED_A;
      ALLRED_A:
        if (tick && timer_q == AR_END) state_d = ped_pending_q ? WALK : S_GREEN;
      S_GREEN:
        if (tick && ((timer_q >= MIN_END && !side_sensor) || timer_q == MAX_END)) state_d = S_YELLOW;
      S_YELLOW:
        if (tick && timer_q == YEL_END) state_d = ALLRED_B;
      WALK:
        if (tick && timer_q == WALK_END) state_d = ALLRED_B;
      ALLRED_B:
        if (tick && timer_q == AR_END) state_d = M_GREEN;
      default:
        state_d = M_GREEN;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick && timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end

    // A press arriving on the cycle we enter WALK is absorbed by that walk.
    ped_pending_d = (state_q == WALK) ? 1'b0 : (ped_pending_q | ped_req);
  end

  assign main_g = (state_q == M_GREEN);
  assign main_y = (state_q == M_YELLOW);
  assign main_r = ~(main_g | main_y);
  assign side_g = (state_q == S_GREEN);
  assign side_y = (state_q == S_YELLOW);
  assign side_r = ~(side_g | side_y);
  assign walk   = (state_q == WALK);
  assign phase  = state_q;

endmodule
